cordic_iter_sequencer: RTL

//  Control FSM that runs one CORDIC operation over a DEPTH_ITERATION-stage iterative datapath.
//  - Accepts a start handshake and pulses the x/y/z operand load.
//  - Steps the iteration index. The index drives the arctangent ROM address and the shift amount.
//  - Computes the per-iteration rotation direction.
//  - Presents the result with a valid/ready handshake.

---
 rtl/cordic_pkg.sv | 24 ++
 rtl/cordic_iter_cnt.sv | 41 ++++
 rtl/cordic_iter_sequencer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC iteration sequencer.
// Holds the sequencer state enum, mode/quadrant codes and default sizing.
package cordic_pkg;

    localparam int CORDIC_DEPTH_DEF  = 15;
    localparam int CORDIC_ADDR_W_DEF = 4;

    localparam logic CORDIC_MODE_ROT = 1'b0;
    localparam logic CORDIC_MODE_VEC = 1'b1;

    localparam logic [1:0] CORDIC_QUAD_0 = 2'b00;
    localparam logic [1:0] CORDIC_QUAD_1 = 2'b01;
    localparam logic [1:0] CORDIC_QUAD_2 = 2'b10;
    localparam logic [1:0] CORDIC_QUAD_3 = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_PRE  = 3'd2,
        ST_ITER = 3'd3,
        ST_DONE = 3'd4
    } cordic_state_e;

endpackage

// File: rtl/cordic_iter_cnt.sv
// Iteration index counter for the CORDIC sequencer.
// Ports: clk, rst (async, active-high), clr, en -> idx, tc.
// idx counts up while en is high and saturates at DEPTH-1 (tc=1).
module cordic_iter_cnt #(
    parameter int DEPTH  = 15,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    output logic [ADDR_W-1:0] idx,
    output logic              tc
);

    localparam logic [ADDR_W-1:0] TC_VAL = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] idx_d;

    assign tc  = (idx_q == TC_VAL);
    assign idx = idx_q;

    always_comb begin
        idx_d = idx_q;
        if (clr) begin
            idx_d = '0;
        end else if (en && !tc) begin
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/cordic_iter_sequencer.sv
// Control FSM running one CORDIC operation over an iterative datapath.
// Ports: start_valid/start_ready, mode, angle_quad, z_sign, y_sign, abort
//   in; load, iter_en, rom_addr, shift_amt, dir, pre_rot, pre_dir, busy,
//   res_valid out; res_ready in. clk, rst (async, active-high).
// Optional +/-90 degree pre-rotation is built with CORDIC_QUAD_CORR_EN.
module cordic_iter_sequencer
    import cordic_pkg::*;
#(
    parameter int DEPTH_ITERATION = CORDIC_DEPTH_DEF,
    parameter int ADDR_W          = CORDIC_ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_valid,
    output logic              start_ready,
    input  logic              mode,
    input  logic [1:0]        angle_quad,
    input  logic              z_sign,
    input  logic              y_sign,
    input  logic              abort,
    output logic              load,
    output logic              iter_en,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [ADDR_W-1:0] shift_amt,
    output logic              dir,
    output logic              pre_rot,
    output logic              pre_dir,
    output logic              busy,
    output logic              res_valid,
    input  logic              res_ready
);

    cordic_state_e state_q;
    cordic_state_e state_d;
    logic          mode_q;
    logic          mode_d;
    logic          cnt_clr;
    logic          cnt_en;
    logic [ADDR_W-1:0] idx;
    logic          tc;
    logic          accept;

    cordic_iter_cnt #(
        .DEPTH  (DEPTH_ITERATION),
        .ADDR_W (ADDR_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .idx (idx),
        .tc  (tc)
    );

    assign accept = start_valid && start_ready;

`ifdef CORDIC_QUAD_CORR_EN
    logic [1:0] quad_q;
    logic [1:0] quad_d;
    logic       pre_take;

    // Only rotation targets in quadrants 1/2 need the 90 degree pre-step.
    assign pre_take = (mode_q == CORDIC_MODE_ROT) &&
                      ((quad_q == CORDIC_QUAD_1) ||
                       (quad_q == CORDIC_QUAD_2));

    always_comb begin
        quad_d = quad_q;
        if (state_q == ST_IDLE && accept) begin
            quad_d = angle_quad;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quad_q <= CORDIC_QUAD_0;
        end else begin
            quad_q <= quad_d;
        end
    end

    assign pre_rot = (state_q == ST_PRE);
    assign pre_dir = pre_rot && (quad_q == CORDIC_QUAD_1);
`else
    logic unused_quad;

    assign unused_quad = ^angle_quad;
    assign pre_rot     = 1'b0;
    assign pre_dir     = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_LOAD;
                    mode_d  = mode;
                end
            end
            ST_LOAD: begin
                cnt_clr = 1'b1;
                state_d = ST_ITER;
`ifdef CORDIC_QUAD_CORR_EN
                if (pre_take) begin
                    state_d = ST_PRE;
                end
`endif
            end
            ST_PRE: begin
`ifdef CORDIC_QUAD_CORR_EN
                state_d = ST_ITER;
`else
                state_d = ST_IDLE;
`endif
            end
            ST_ITER: begin
                cnt_en = 1'b1;
                if (tc) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Cancel overrides everything and leaves the index at zero.
        if (abort) begin
            state_d = ST_IDLE;
            cnt_clr = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= CORDIC_MODE_ROT;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
        end
    end

    assign start_ready = (state_q == ST_IDLE) && !abort;
    assign load        = (state_q == ST_LOAD);
    assign iter_en     = (state_q == ST_ITER);
    assign busy        = (state_q != ST_IDLE);
    // Abort withdraws a pending result so no handshake can complete.
    assign res_valid   = (state_q == ST_DONE) && !abort;
    assign rom_addr    = iter_en ? idx : '0;
    assign shift_amt   = iter_en ? idx : '0;
    // Rotation drives z to zero, vectoring drives y to zero.
    assign dir = iter_en &&
                 ((mode_q == CORDIC_MODE_VEC) ? y_sign : !z_sign);

endmodule
